weight_pingpong_buffer: RTL and testbench
=========================================

WEIGHT_PINGPONG_BUFFER -- requirements
Module: weight_pingpong_buffer

Interface
REQ-001 SHALL have parameter DW, default 32, meaning weight word width in bits; DW is a multiple of 8.
REQ-002 SHALL have parameter AW, default 32, meaning AXI byte-address width.
REQ-003 SHALL have parameter BURST, default 32, range 2..256, meaning words per bank and per AXI burst.
REQ-004 SHALL have parameter RW, default 8, meaning width of the reuse-count input.
REQ-005 SHALL use one clock and a synchronous active-high reset; all state changes on the rising edge of clk.
REQ-006 SHALL have ports, in this order (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- weight_load  in  1  single-cycle request to fetch one burst
- init_addr_en  in  1  with weight_load: take start address from init_addr
- init_addr  in  AW  burst start byte address
- reuse  in  RW  extra replays of each bank, sampled with weight_load
- araddr  out  AW  AXI read address
- arlen  out  8  fixed BURST-1
- arvalid  out  1  address valid
- arready  in  1  address ready
- rdata  in  DW  read data
- rvalid  in  1  read data valid
- rlast  in  1  last beat
- rready  out  1  read data ready
- dw_out  out  DW  weight word to compute
- dw_valid  out  1  dw_out valid
- dw_ready  in  1  compute accepts dw_out
- dw_comp  out  1  one-cycle pulse: bank fully consumed and released
- ld_busy  out  1  high when weight_load would be dropped
- ld_drop  out  1  one-cycle pulse: weight_load dropped

Function
REQ-007 SHALL hold two banks of BURST x DW words, each with a full flag and a stored reuse value.
REQ-008 SHALL run a fetch FSM with states IDLE, ADDR, DATA.
REQ-009 SHALL, in IDLE with at least one free bank, accept weight_load, select the lowest-index free bank, latch reuse and go to ADDR.
REQ-010 SHALL, on an accepted load, set araddr to init_addr when init_addr_en=1, else to the internal next_addr register.
REQ-011 SHALL set next_addr to araddr + BURST*(DW/8) on AR handshake, with wrap modulo 2^AW.
REQ-012 SHALL hold arvalid=1 with a stable araddr in ADDR until arready=1, then go to DATA.
REQ-013 SHALL drive rready=1 only in DATA and write each rvalid&rready beat to consecutive words of the target bank.
REQ-014 SHALL, on the BURST-th accepted beat, set the bank full and return to IDLE, whatever the state of rlast; rlast on an earlier beat is ignored.
REQ-015 SHALL assert ld_busy = (state != IDLE) | both banks full.
REQ-016 SHALL drop weight_load while ld_busy=1 and pulse ld_drop the next cycle; the drop has no other effect.
REQ-017 SHALL stream from the read bank pointer (reset 0): word 0..BURST-1 in order, with dw_valid=1 while that bank is full.
REQ-018 SHALL present the first word of a newly full bank with dw_valid=1 on the cycle after the bank's final beat (1-cycle latency).
REQ-019 SHALL advance the word on dw_valid&dw_ready; while dw_ready=0, dw_out and dw_valid stay stable.
REQ-020 SHALL replay the bank reuse+1 times in total: after word BURST-1 is accepted, restart at word 0 while replays remain.
REQ-021 SHALL, after the final replay's last word is accepted, clear full, pulse dw_comp, toggle the read pointer and drop dw_valid unless the other bank is already full.
REQ-022 SHALL allow the fetch into one bank to run concurrently with streaming from the other.
REQ-023 SHALL, when a bank frees and weight_load arrives in the same cycle, treat the bank as free and accept the load.
REQ-024 SHALL service fetches in load order: the read pointer always reaches banks in fill order.

Reset
REQ-025 SHALL, on rst=1, go to IDLE, clear both full flags, and clear the read pointer, word/replay counters and next_addr to 0.
REQ-026 SHALL, on rst=1, drive arvalid, rready, dw_valid, dw_comp and ld_drop to 0, and araddr and dw_out to 0.
REQ-027 SHALL treat reset mid-burst as abort: stray rvalid beats after reset are ignored in IDLE.

Verification
REQ-028 Basic: weight_load=1, init_addr_en=1, init_addr=90, reuse=0 -> araddr=90, arlen=31; 32 beats of data k; dw_out = 0..31 in order, dw_comp once.
REQ-029 Sequential address: second load with init_addr_en=0 -> araddr=218 (90+128).
REQ-030 Ping-pong: load A, then load B while A streams with dw_ready=1 -> B's first word valid on the cycle after A's last word; no gap once B is full.
REQ-031 Reuse: reuse=2 -> 96 words delivered (0..31 three times), dw_comp only after word 96.
REQ-032 Overflow/stall: both banks full with dw_ready=0, weight_load -> ld_drop pulse, no AR; dw_out stays stable during 10 stall cycles.
REQ-033 Reset mid-DATA after 5 beats -> all outputs 0 next cycle; a fresh load restarts cleanly at bank 0.

Source files
------------

// File: rtl/weight_pingpong_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : weight_pingpong_buffer
//  Purpose  : Double-buffered weight store. A fetch FSM pulls BURST-word AXI
//             read bursts into one of two banks while the other bank streams
//             words (optionally replayed) to the compute datapath.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst           clock, synchronous active-high reset
//    weight_load        single-cycle request to fetch one burst
//    init_addr_en       with weight_load: start address from init_addr
//    init_addr          burst start byte address
//    reuse              extra replays of the bank, sampled with weight_load
//    araddr/arlen/arvalid/arready   AXI read address channel
//    rdata/rvalid/rlast/rready      AXI read data channel
//    dw_out/dw_valid/dw_ready       weight stream to compute
//    dw_comp            pulse: a bank was fully consumed and released
//    ld_busy            weight_load would be dropped this cycle
//    ld_drop            pulse: a weight_load was dropped
// ============================================================================
module weight_pingpong_buffer #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int BURST = 32,
  parameter int RW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          weight_load,
  input  logic          init_addr_en,
  input  logic [AW-1:0] init_addr,
  input  logic [RW-1:0] reuse,
  output logic [AW-1:0] araddr,
  output logic [7:0]    arlen,
  output logic          arvalid,
  input  logic          arready,
  input  logic [DW-1:0] rdata,
  input  logic          rvalid,
  input  logic          rlast,
  output logic          rready,
  output logic [DW-1:0] dw_out,
  output logic          dw_valid,
  input  logic          dw_ready,
  output logic          dw_comp,
  output logic          ld_busy,
  output logic          ld_drop
);

  localparam int            CW     = $clog2(BURST);
  localparam logic [CW-1:0] LAST   = CW'(BURST - 1);
  localparam logic [AW-1:0] STRIDE = AW'(BURST * (DW / 8));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t        state_q;
  logic          fill_bank_q;
  logic [CW-1:0] beat_q;
  logic [AW-1:0] araddr_q;
  logic [AW-1:0] next_addr_q;
  logic          arvalid_q;
  logic          rready_q;
  logic [1:0]    full_q;
  logic [RW-1:0] reuse_q [2];
  logic          rd_ptr_q;
  logic [CW-1:0] word_q;
  logic [RW-1:0] rep_q;
  logic          dw_comp_q;
  logic          ld_drop_q;
  logic [DW-1:0] mem_q [2][BURST];

  logic       w_dw_fire;
  logic       w_release;
  logic [1:0] w_full_eff;
  logic       w_ld_busy;
  logic       w_accept;
  logic       w_free_bank;
  logic       w_beat;
  logic       w_last_beat;
  logic       w_other_live;
  logic       w_unused_rlast;

  // Burst length is fixed; the beat counter alone decides completion.
  assign w_unused_rlast = rlast;

  assign w_dw_fire = full_q[rd_ptr_q] & dw_ready;
  assign w_release = w_dw_fire & (word_q == LAST) & (rep_q == reuse_q[rd_ptr_q]);

  // A bank released this cycle counts as free for a load arriving this cycle.
  assign w_full_eff[0] = full_q[0] & ~(w_release & ~rd_ptr_q);
  assign w_full_eff[1] = full_q[1] & ~(w_release &  rd_ptr_q);

  assign w_ld_busy   = (state_q != S_IDLE) | (&w_full_eff);
  assign w_accept    = weight_load & ~w_ld_busy;
  assign w_free_bank = w_full_eff[0];  // lowest-index free bank

  assign w_beat      = rvalid & rready_q;
  assign w_last_beat = w_beat & (beat_q == LAST);

  // The other bank holds or is receiving the next burst in load order.
  // When it does not, the pointer returns to bank 0: with both banks empty
  // the next load lands in bank 0, so fill order and read order stay aligned.
  assign w_other_live = full_q[~rd_ptr_q]
                      | ((state_q != S_IDLE) & (fill_bank_q == ~rd_ptr_q));

  assign araddr   = araddr_q;
  assign arlen    = 8'(BURST - 1);
  assign arvalid  = arvalid_q;
  assign rready   = rready_q;
  assign dw_valid = full_q[rd_ptr_q];
  assign dw_out   = full_q[rd_ptr_q] ? mem_q[rd_ptr_q][word_q] : '0;
  assign dw_comp  = dw_comp_q;
  assign ld_busy  = w_ld_busy;
  assign ld_drop  = ld_drop_q;

  // Bank storage carries no reset; the full flags qualify its contents.
  always_ff @(posedge clk) begin
    if (w_beat) begin
      mem_q[fill_bank_q][beat_q] <= rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fill_bank_q <= 1'b0;
      beat_q      <= '0;
      araddr_q    <= '0;
      next_addr_q <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      full_q      <= 2'b00;
      reuse_q[0]  <= '0;
      reuse_q[1]  <= '0;
      rd_ptr_q    <= 1'b0;
      word_q      <= '0;
      rep_q       <= '0;
      dw_comp_q   <= 1'b0;
      ld_drop_q   <= 1'b0;
    end else begin
      ld_drop_q <= weight_load & w_ld_busy;
      dw_comp_q <= w_release;

      // ---------------- fetch FSM ----------------
      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            fill_bank_q          <= w_free_bank;
            reuse_q[w_free_bank] <= reuse;
            araddr_q             <= init_addr_en ? init_addr : next_addr_q;
            arvalid_q            <= 1'b1;
            beat_q               <= '0;
            state_q              <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (arready) begin
            arvalid_q   <= 1'b0;
            next_addr_q <= araddr_q + STRIDE;
            rready_q    <= 1'b1;
            state_q     <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_beat) begin
            beat_q <= beat_q + CW'(1);
            if (beat_q == LAST) begin
              rready_q <= 1'b0;
              state_q  <= S_IDLE;
            end
          end
        end
        default: begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase

      // ---------------- stream side ----------------
      if (w_dw_fire) begin
        if (word_q == LAST) begin
          word_q <= '0;
          if (rep_q == reuse_q[rd_ptr_q]) begin
            rep_q <= '0;
          end else begin
            rep_q <= rep_q + RW'(1);
          end
        end else begin
          word_q <= word_q + CW'(1);
        end
      end

      if (w_release) begin
        full_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q         <= w_other_live ? ~rd_ptr_q : 1'b0;
      end

      // The bank being filled is never the bank being released.
      if (w_last_beat) begin
        full_q[fill_bank_q] <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_weight_pingpong_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_weight_pingpong_buffer
//  Purpose  : Self-checking bench for weight_pingpong_buffer. An AXI read
//             slave model supplies bursts; expected weight words are queued
//             per burst (including replays) and compared as they stream out.
//  Revision : 1.0  initial release
// ============================================================================
module tb_weight_pingpong_buffer;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int BURST = 32;
  localparam int RW    = 8;

  logic          clk          = 1'b0;
  logic          rst          = 1'b1;
  logic          weight_load  = 1'b0;
  logic          init_addr_en = 1'b0;
  logic [AW-1:0] init_addr    = '0;
  logic [RW-1:0] reuse        = '0;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic          arvalid;
  logic          arready      = 1'b1;
  logic [DW-1:0] rdata        = '0;
  logic          rvalid       = 1'b0;
  logic          rlast        = 1'b0;
  logic          rready;
  logic [DW-1:0] dw_out;
  logic          dw_valid;
  logic          dw_ready     = 1'b1;
  logic          dw_comp;
  logic          ld_busy;
  logic          ld_drop;

  always #5 clk = ~clk;

  weight_pingpong_buffer #(.DW(DW), .AW(AW), .BURST(BURST), .RW(RW)) u_dut (
    .clk(clk), .rst(rst), .weight_load(weight_load), .init_addr_en(init_addr_en),
    .init_addr(init_addr), .reuse(reuse), .araddr(araddr), .arlen(arlen),
    .arvalid(arvalid), .arready(arready), .rdata(rdata), .rvalid(rvalid),
    .rlast(rlast), .rready(rready), .dw_out(dw_out), .dw_valid(dw_valid),
    .dw_ready(dw_ready), .dw_comp(dw_comp), .ld_busy(ld_busy), .ld_drop(ld_drop)
  );

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard and model state
  logic [DW-1:0] sb_q[$];
  int            comp_q[$];
  int            ru_q[$];
  logic [AW-1:0] addr_q[$];
  logic [AW-1:0] model_next = '0;
  int beats_left = 0, beat_idx = 0, burst_num = 0, cur_base = 0, cur_ru = 0;
  int consumed = 0, comp_cnt = 0, drop_cnt = 0, ar_cnt = 0, stray = 0, cycle = 0;
  int first_pop = -1, last_pop = -1;
  bit gaps = 1'b0, rand_ready = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: score handshakes that occur on the coming edge, advance,
  // then drive the AXI slave and consumer for the next cycle.
  task automatic tick();
    bit ar_hs, r_hs, dw_hs;
    ar_hs = arvalid && arready;
    r_hs  = rvalid && rready;
    dw_hs = dw_valid && dw_ready;
    if (dw_hs) begin
      check_val("dw_expected", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) check_val("dw_out", dw_out, sb_q.pop_front());
      consumed++;
      if (first_pop < 0) first_pop = cycle;
      last_pop = cycle;
    end
    if (ar_hs) begin
      ar_cnt++;
      check_val("ar_expected", addr_q.size() != 0, 1);
      if (addr_q.size() != 0) begin
        check_val("araddr", araddr, addr_q.pop_front());
        check_val("arlen", arlen, BURST - 1);
        cur_ru = ru_q.pop_front();
      end
    end
    if (r_hs) begin
      check_val("beat_expected", beats_left != 0, 1);
      if (beats_left != 0) begin
        beat_idx++;
        beats_left--;
        if (beats_left == 0) begin
          for (int r = 0; r <= cur_ru; r++)
            for (int k = 0; k < BURST; k++) sb_q.push_back(DW'(cur_base + k));
          comp_q.push_back(BURST * (cur_ru + 1));
        end
      end
    end
    @(posedge clk);
    #1;
    cycle++;
    if (dw_comp) begin
      comp_cnt++;
      check_val("comp_expected", comp_q.size() != 0, 1);
      if (comp_q.size() != 0) check_val("comp_len", consumed, comp_q.pop_front());
      consumed = 0;
    end
    if (ld_drop) drop_cnt++;
    if (ar_hs) begin
      beats_left = BURST;
      beat_idx   = 0;
      cur_base   = burst_num * 256;
      burst_num++;
    end
    arready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
    if (rand_ready) dw_ready = 1'($urandom_range(0, 1));
    if (stray > 0) begin
      rvalid = 1'b1;
      rdata  = 32'hdead;
      rlast  = 1'b1;
      stray--;
    end else begin
      rvalid = (beats_left > 0) && (gaps ? ($urandom_range(0, 2) != 0) : 1'b1);
      rdata  = DW'(cur_base + beat_idx);
      // an early rlast in gap mode must be ignored
      rlast  = (beat_idx == BURST - 1) || (gaps && beat_idx == 7);
    end
  endtask

  task automatic do_load(input bit en, input logic [AW-1:0] addr, input int ru, input bit exp_acc);
    logic [AW-1:0] ea;
    int d0;
    weight_load  = 1'b1;
    init_addr_en = en;
    init_addr    = addr;
    reuse        = RW'(ru);
    check_val("ld_busy", ld_busy, !exp_acc);
    if (exp_acc) begin
      ea = en ? addr : model_next;
      addr_q.push_back(ea);
      ru_q.push_back(ru);
      model_next = ea + AW'(BURST * (DW / 8));
    end
    d0 = drop_cnt;
    tick();
    weight_load  = 1'b0;
    init_addr_en = 1'b0;
    check_val("ld_drop", drop_cnt - d0, !exp_acc);
    check_val("arvalid_after_load", arvalid, exp_acc);
  endtask

  task automatic wait_fill();
    int n = 0;
    while ((addr_q.size() != 0 || beats_left != 0) && n < 1000) begin
      tick();
      n++;
    end
    check_val("fill_in_time", n < 1000, 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb_q.size() != 0 || comp_q.size() != 0 || addr_q.size() != 0 || beats_left != 0)
           && n < 4000) begin
      tick();
      n++;
    end
    check_val("drain_in_time", n < 4000, 1);
  endtask

  task automatic apply_reset();
    rst         = 1'b1;
    weight_load = 1'b0;
    @(posedge clk);
    #1;
    cycle++;
    check_val("rst_araddr", araddr, 0);
    check_val("rst_arvalid", arvalid, 0);
    check_val("rst_rready", rready, 0);
    check_val("rst_dw_valid", dw_valid, 0);
    check_val("rst_dw_out", dw_out, 0);
    check_val("rst_dw_comp", dw_comp, 0);
    check_val("rst_ld_drop", ld_drop, 0);
    check_val("rst_ld_busy", ld_busy, 0);
    rst = 1'b0;
    sb_q.delete();
    comp_q.delete();
    ru_q.delete();
    addr_q.delete();
    model_next = '0;
    beats_left = 0;
    beat_idx   = 0;
    consumed   = 0;
    rvalid     = 1'b0;
  endtask

  initial begin
    int c0, a0, n;

    apply_reset();

    // basic burst at 90, single pass
    c0 = comp_cnt;
    do_load(1'b1, 32'd90, 0, 1'b1);
    wait_drain();
    check_val("basic_comp_count", comp_cnt - c0, 1);

    // sequential address with random AXI gaps: 90 + 128 = 218
    gaps = 1'b1;
    do_load(1'b0, 32'h0, 0, 1'b1);
    wait_drain();
    gaps = 1'b0;

    // ping-pong: B fills while A replays once; stream must be gapless
    first_pop = -1;
    c0 = comp_cnt;
    do_load(1'b1, 32'd1000, 1, 1'b1);
    wait_fill();
    do_load(1'b0, 32'h0, 0, 1'b1);
    wait_drain();
    check_val("pingpong_gapless", last_pop - first_pop + 1, 96);
    check_val("pingpong_comp_count", comp_cnt - c0, 2);

    // reuse = 2 with random ready/valid
    gaps = 1'b1;
    rand_ready = 1'b1;
    c0 = comp_cnt;
    do_load(1'b1, 32'h200, 2, 1'b1);
    wait_drain();
    check_val("reuse_comp_count", comp_cnt - c0, 1);
    gaps = 1'b0;
    rand_ready = 1'b0;

    // overflow and stall: both banks full, consumer stalled
    dw_ready = 1'b0;
    c0 = comp_cnt;
    do_load(1'b1, 32'h3000, 0, 1'b1);
    wait_fill();
    do_load(1'b0, 32'h0, 0, 1'b1);
    wait_fill();
    a0 = ar_cnt;
    do_load(1'b1, 32'h5000, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check_val("stall_dw_valid", dw_valid, 1);
      check_val("stall_dw_out", dw_out, sb_q[0]);
      tick();
    end
    check_val("no_ar_on_drop", ar_cnt - a0, 0);
    dw_ready = 1'b1;
    wait_drain();
    check_val("stall_comp_count", comp_cnt - c0, 2);

    // reset in the middle of a data burst
    do_load(1'b1, 32'h40, 0, 1'b1);
    n = 0;
    while (!(beats_left > 0 && beat_idx >= 5) && n < 200) begin
      tick();
      n++;
    end
    check_val("five_beats_in_time", n < 200, 1);
    apply_reset();
    rvalid = 1'b1;
    stray  = 3;
    for (int i = 0; i < 4; i++) begin
      check_val("post_rst_rready", rready, 0);
      check_val("post_rst_dw_valid", dw_valid, 0);
      tick();
    end
    c0 = comp_cnt;
    do_load(1'b0, 32'h0, 0, 1'b1);
    wait_drain();
    check_val("restart_comp_count", comp_cnt - c0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
